// File: rtl/cordic_sequencer.sv
// Iteration controller for a 16-bit CORDIC rotation engine: sequences X/Y/Z
// micro-rotation updates through one shared external add/subtract ALU.
module cordic_sequencer #(
    parameter int WIDTH = 16,
    parameter int ITER  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic signed [WIDTH-1:0] X_in,
    input  logic signed [WIDTH-1:0] Y_in,
    input  logic signed [WIDTH-1:0] Z_in,
    output logic                    Busy,
    output logic                    Done,
    output logic signed [WIDTH-1:0] X_out,
    output logic signed [WIDTH-1:0] Y_out,
    output logic signed [WIDTH-1:0] Z_out,
    output logic signed [WIDTH-1:0] Alu_A,
    output logic signed [WIDTH-1:0] Alu_B,
    output logic                    Alu_Sign,
    input  logic signed [WIDTH-1:0] Alu_Result
);

    localparam int IW = 4;

    typedef enum logic [2:0] {
        IDLE,
        OPX,
        OPY,
        OPZ,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic        [IW-1:0]    i_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q, xt_q;
    logic                    last_iter;
    logic                    z_neg;

    // atan(2^-i) scaled so that 0x4000 = pi/2
    function automatic logic [15:0] atan16(input logic [IW-1:0] idx);
        case (idx)
            4'd0:    atan16 = 16'h2000;
            4'd1:    atan16 = 16'h12E4;
            4'd2:    atan16 = 16'h09FB;
            4'd3:    atan16 = 16'h0511;
            4'd4:    atan16 = 16'h028B;
            4'd5:    atan16 = 16'h0146;
            4'd6:    atan16 = 16'h00A3;
            4'd7:    atan16 = 16'h0051;
            4'd8:    atan16 = 16'h0029;
            4'd9:    atan16 = 16'h0014;
            4'd10:   atan16 = 16'h000A;
            4'd11:   atan16 = 16'h0005;
            4'd12:   atan16 = 16'h0003;
            4'd13:   atan16 = 16'h0001;
            4'd14:   atan16 = 16'h0001;
            default: atan16 = 16'h0000;
        endcase
    endfunction

    assign last_iter = (i_q == IW'(ITER - 1));
    // Z only moves at the end of OPZ, so the direction is stable for the whole iteration
    assign z_neg     = z_q[WIDTH-1];

    assign X_out = x_q;
    assign Y_out = y_q;
    assign Z_out = z_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        Alu_A    = '0;
        Alu_B    = '0;
        Alu_Sign = 1'b0;
        Busy     = 1'b1;
        Done     = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Start) state_d = OPX;
            end
            OPX: begin
                Alu_A    = x_q;
                Alu_B    = y_q >>> i_q;
                Alu_Sign = ~z_neg;
                state_d  = OPY;
            end
            OPY: begin
                Alu_A    = y_q;
                Alu_B    = x_q >>> i_q;
                Alu_Sign = z_neg;
                state_d  = OPZ;
            end
            OPZ: begin
                Alu_A    = z_q;
                Alu_B    = WIDTH'(atan16(i_q));
                Alu_Sign = ~z_neg;
                state_d  = last_iter ? DONE : OPX;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                Busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // X is updated late (via xt) so OPY still sees the pre-rotation X
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            i_q  <= '0;
            x_q  <= '0;
            y_q  <= '0;
            z_q  <= '0;
            xt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        x_q <= X_in;
                        y_q <= Y_in;
                        z_q <= Z_in;
                        i_q <= '0;
                    end
                end
                OPX: xt_q <= Alu_Result;
                OPY: y_q  <= Alu_Result;
                OPZ: begin
                    z_q <= Alu_Result;
                    x_q <= xt_q;
                    if (!last_iter) i_q <= i_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer: nominal rotation, per-cycle ALU operands,
// ignored Start while busy, reset mid-run and back-to-back runs.
module tb_cordic_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] X_in, Y_in, Z_in;
    logic        Busy, Done;
    logic [15:0] X_out, Y_out, Z_out;
    logic [15:0] Alu_A, Alu_B;
    logic        Alu_Sign;
    logic [15:0] Alu_Result;

    int checks = 0;
    int errors = 0;

    // Hand-derived operands for X=0x4000, Y=0, Z=0, one entry per cycle after the accepting edge
    localparam logic [15:0] EA [12] = '{16'h4000, 16'h0000, 16'h0000,
                                        16'h4000, 16'h4000, 16'hE000,
                                        16'h6000, 16'h2000, 16'hF2E4,
                                        16'h6800, 16'h0800, 16'hFCDF};
    localparam logic [15:0] EB [12] = '{16'h0000, 16'h4000, 16'h2000,
                                        16'h2000, 16'h2000, 16'h12E4,
                                        16'h0800, 16'h1800, 16'h09FB,
                                        16'h0100, 16'h0D00, 16'h0511};
    localparam logic        ES [12] = '{1'b1, 1'b0, 1'b1,
                                        1'b0, 1'b1, 1'b0,
                                        1'b0, 1'b1, 1'b0,
                                        1'b0, 1'b1, 1'b0};
    localparam logic [15:0] EZ [3] = '{16'hE000, 16'hF2E4, 16'hFCDF};
    localparam logic [15:0] EY [3] = '{16'h4000, 16'h2000, 16'h0800};
    localparam logic [15:0] EX [3] = '{16'h4000, 16'h6000, 16'h6800};

    cordic_sequencer #(.WIDTH(16), .ITER(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .X_in       (X_in),
        .Y_in       (Y_in),
        .Z_in       (Z_in),
        .Busy       (Busy),
        .Done       (Done),
        .X_out      (X_out),
        .Y_out      (Y_out),
        .Z_out      (Z_out),
        .Alu_A      (Alu_A),
        .Alu_B      (Alu_B),
        .Alu_Sign   (Alu_Sign),
        .Alu_Result (Alu_Result)
    );

    always #5 Clk = ~Clk;

    assign Alu_Result = Alu_Sign ? (Alu_A - Alu_B) : (Alu_A + Alu_B);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 16'(Busy), 16'h0);
        chk({tag, ".done"}, 16'(Done), 16'h0);
        chk({tag, ".x"}, X_out, 16'h0);
        chk({tag, ".y"}, Y_out, 16'h0);
        chk({tag, ".z"}, Z_out, 16'h0);
        chk({tag, ".a"}, Alu_A, 16'h0);
        chk({tag, ".b"}, Alu_B, 16'h0);
        chk({tag, ".s"}, 16'(Alu_Sign), 16'h0);
    endtask

    // Called 1ns after the accepting edge; ends 1ns after edge k+13 (back in IDLE).
    task automatic run_check(input string tag, input bit noise);
        for (int t = 0; t < 12; t++) begin
            chk($sformatf("%s.t%0d.a", tag, t), Alu_A, EA[t]);
            chk($sformatf("%s.t%0d.b", tag, t), Alu_B, EB[t]);
            chk($sformatf("%s.t%0d.s", tag, t), 16'(Alu_Sign), 16'(ES[t]));
            chk($sformatf("%s.t%0d.busy", tag, t), 16'(Busy), 16'h1);
            chk($sformatf("%s.t%0d.done", tag, t), 16'(Done), 16'h0);
            if (t == 0) chk($sformatf("%s.load.x", tag), X_out, 16'h4000);
            if (t > 0 && t % 3 == 0) begin
                chk($sformatf("%s.it%0d.z", tag, t / 3 - 1), Z_out, EZ[t/3-1]);
                chk($sformatf("%s.it%0d.y", tag, t / 3 - 1), Y_out, EY[t/3-1]);
                chk($sformatf("%s.it%0d.x", tag, t / 3 - 1), X_out, EX[t/3-1]);
            end
            if (noise && t == 3) begin
                Start = 1'b1; X_in = 16'h1111; Y_in = 16'h2222; Z_in = 16'h3333;
            end
            if (noise && t == 4) Start = 1'b0;
            tick();
        end
        if (noise) begin
            Start = 1'b1; X_in = 16'h0ABC; Y_in = 16'h0DEF; Z_in = 16'hC000;
        end
        chk({tag, ".done_pulse"}, 16'(Done), 16'h1);
        chk({tag, ".done_busy"}, 16'(Busy), 16'h1);
        chk({tag, ".x_final"}, X_out, 16'h6900);
        chk({tag, ".y_final"}, Y_out, 16'hFB00);
        chk({tag, ".z_final"}, Z_out, 16'h01F0);
        chk({tag, ".done_a"}, Alu_A, 16'h0);
        chk({tag, ".done_b"}, Alu_B, 16'h0);
        chk({tag, ".done_s"}, 16'(Alu_Sign), 16'h0);
        tick();
        if (noise) Start = 1'b0;
        chk({tag, ".after_done"}, 16'(Done), 16'h0);
        chk({tag, ".after_busy"}, 16'(Busy), 16'h0);
        chk({tag, ".hold_x"}, X_out, 16'h6900);
        chk({tag, ".hold_y"}, Y_out, 16'hFB00);
        chk({tag, ".hold_z"}, Z_out, 16'h01F0);
    endtask

    task automatic launch_nominal;
        X_in = 16'h4000; Y_in = 16'h0000; Z_in = 16'h0000;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0;
        X_in = 16'h0; Y_in = 16'h0; Z_in = 16'h0;
        #1;
        chk_all_zero("rst_init");
        tick(); tick();
        Reset = 1'b0;
        tick(); tick();
        chk_all_zero("rst_release");

        // Nominal run
        launch_nominal();
        run_check("nom", 1'b0);

        // Start pulses during OPX of iteration 1 and in DONE must be ignored
        launch_nominal();
        run_check("busy_start", 1'b1);
        tick();
        chk("busy_start.stay_idle", 16'(Busy), 16'h0);
        chk("busy_start.keep_z", Z_out, 16'h01F0);

        // Reset during iteration 2 OPY, asserted mid-cycle
        launch_nominal();
        repeat (7) tick();
        chk("midrun.in_opy.a", Alu_A, 16'h2000);
        #3 Reset = 1'b1;
        #1;
        chk_all_zero("midrun_async");
        tick();
        Reset = 1'b0;
        begin
            int done_seen = 0;
            for (int c = 0; c < 16; c++) begin
                if (Done) done_seen++;
                tick();
            end
            chk("midrun.no_done", 16'(done_seen), 16'h0);
        end
        chk("midrun.idle", 16'(Busy), 16'h0);
        launch_nominal();
        run_check("post_rst", 1'b0);

        // Back-to-back with Start held high: accepting edges 14 cycles apart
        X_in = 16'h4000; Y_in = 16'h0000; Z_in = 16'h0000;
        Start = 1'b1;
        tick();
        run_check("b2b0", 1'b0);
        tick();
        run_check("b2b1", 1'b0);
        tick();
        run_check("b2b2", 1'b0);
        Start = 1'b0;
        tick();
        chk("b2b.end_idle", 16'(Busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
